// File: rtl/pingpong_frame_bram.sv
// ============================================================================
// Module      : pingpong_frame_bram
// Description : Double-buffered byte-writable frame store. The writer fills the
//               back bank and the reader drains the front bank. The banks swap
//               at the reader's frame boundary, so a frame never tears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pingpong_frame_bram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [ADDR_WIDTH-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      rd_valid_o,
    input  logic                      swap_req_i,
    input  logic                      rd_frame_end_i,
    output logic                      swap_busy_o,
    output logic                      swap_done_o,
    output logic                      wr_bank_o,
    output logic                      rd_bank_o
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** (ADDR_WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    swap_state_e state_q, state_d;
    logic        wr_bank_q, wr_bank_d;
    logic        swap_done_q, swap_done_d;
    logic        swap_fire;
    logic        rd_bank;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data1_q;
    logic                  rd_valid1_q;

    assign rd_bank = ~wr_bank_q;

    // A request that meets the frame boundary in the same cycle swaps immediately.
    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req_i) begin
                    if (rd_frame_end_i) begin
                        swap_fire = 1'b1;
                    end else begin
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (rd_frame_end_i) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_bank_d   = wr_bank_q ^ swap_fire;
        swap_done_d = swap_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            swap_done_q <= swap_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !rst) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[{wr_bank_q, wr_addr_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // First read stage; data only updates on a request so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid1_q <= 1'b0;
            rd_data1_q  <= '0;
        end else begin
            rd_valid1_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data1_q <= mem_q[{rd_bank, rd_addr_i}];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] rd_data2_q;
            logic                  rd_valid2_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_valid2_q <= 1'b0;
                    rd_data2_q  <= '0;
                end else begin
                    rd_valid2_q <= rd_valid1_q;
                    if (rd_valid1_q) begin
                        rd_data2_q <= rd_data1_q;
                    end
                end
            end

            assign rd_data_o  = rd_data2_q;
            assign rd_valid_o = rd_valid2_q;
        end else begin : g_lat1
            assign rd_data_o  = rd_data1_q;
            assign rd_valid_o = rd_valid1_q;
        end
    endgenerate

    assign swap_busy_o = (state_q == PENDING);
    assign swap_done_o = swap_done_q;
    assign wr_bank_o   = wr_bank_q;
    assign rd_bank_o   = rd_bank;

endmodule

`default_nettype wire
